axi_lite_arb_2to1: RTL
======================

# axi_lite_arb_2to1

Two-requester AXI4-Lite arbiter sharing a single AXI4-Lite master port, such as the peripheral port behind the bit-31 address remap. Read and write paths arbitrate independently with round-robin fairness. Each path allows one outstanding transaction. An optional stage clears the address MSB on the master side.

## Interface
- C_AXI_ADDR_WIDTH, 32, address width on all ports (≥2)
- C_AXI_DATA_WIDTH, 32, data width on all ports (32 or 64)
- One clock; reset is synchronous and active-high.
- aclk  in  1  system clock, all logic on rising edge
- areset  in  1  synchronous active-high reset
- sN_axi_awaddr/awprot/awvalid  in  ADDR/3/1  requester N (N=0,1) write address
- sN_axi_awready  out  1  requester N write-address accept
- sN_axi_wdata/wstrb/wvalid  in  DATA/DATA/8/1  requester N write data
- sN_axi_wready  out  1  requester N write-data accept
- sN_axi_bresp/bvalid  out  2/1  requester N write response
- sN_axi_bready  in  1  requester N response accept
- sN_axi_araddr/arprot/arvalid  in  ADDR/3/1  requester N read address
- sN_axi_arready  out  1  requester N read-address accept
- sN_axi_rdata/rresp/rvalid  out  DATA/2/1  requester N read data
- sN_axi_rready  in  1  requester N read-data accept
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  mirrored  as above  shared master port

## Operation
- Write FSM: W_IDLE, W_ADDR, W_RESP. Read FSM: R_IDLE, R_ADDR, R_DATA. The two FSMs are fully independent.
- Requests:
  - Write request from N: sN_axi_awvalid. Read request from N: sN_axi_arvalid.
- Arbitration, in IDLE:
  - One requester: it is granted.
  - Both requesting: the requester not granted last on that path wins.
  - Per-path last-grant pointer resets to 1, so s0 wins the first tie.
- On grant, the FSM registers grant index, moves to ADDR, and sets flags aw_done=0, w_done=0.
- W_ADDR:
  - m_axi_awvalid = sG_awvalid & ~aw_done. m_axi_wvalid = sG_wvalid & ~w_done.
  - Payload is muxed from sG. sG_awready/wready mirror m_axi_awready/wready, gated by the same terms.
  - Each flag sets on its handshake. When both are set (including the same cycle), go to W_RESP.
- W_RESP:
  - sG_bvalid = m_axi_bvalid, sG_bresp = m_axi_bresp, m_axi_bready = sG_bready.
  - On handshake, go to W_IDLE and update the pointer.
- R_ADDR: m_axi_ar* from sG. On m_axi_arvalid & m_axi_arready, go to R_DATA.
- R_DATA: r channel routed to sG. On rvalid & rready, go to R_IDLE and update the pointer.
- Non-granted requester:
  - All its readies/valids are 0. rdata/bresp/rresp are 0.
  - Its requests stay pending; AXI requires it to hold valid.
- Outside RESP/DATA: m_axi_bready=0, m_axi_rready=0.
- Outside ADDR: m_axi_awvalid/wvalid/arvalid=0. Master payload outputs are 0.
- m_axi_bresp/rresp pass through unmodified, including SLVERR/DECERR.

## Timing
- Reset value of every output is 0. Both FSMs start in IDLE; flags and grant are cleared.
- Reset mid-transaction abandons it immediately; no response is generated.
- Grant latency: sN valid in IDLE at cycle T gives m_axi valid at T+1. FSM state and grant are registered.
- Address, data and response paths are combinational through the granted mux; no added pipeline latency.
- Throughput per path is one transaction per ≥3 cycles: grant, address handshake, response handshake.
- Back-to-back: IDLE is re-entered on the response handshake. A pending request is granted the following cycle.
- A read and a write may run simultaneously, from the same or different requesters.
- W_ADDR tolerates aw before w, w before aw, or both in one cycle.

## Configuration
- AXI_ARB_ADDR_REMAP_EN defined: m_axi_awaddr[C_AXI_ADDR_WIDTH-1] and m_axi_araddr[C_AXI_ADDR_WIDTH-1] are forced to 0. Lower bits pass through.
- Undefined: addresses pass through unmodified.
- Remap is combinational in both cases; latency is unchanged.

## Structure
- Package axi_lite_arb_pkg holds:
  - wr_state_t {W_IDLE, W_ADDR, W_RESP} and rd_state_t {R_IDLE, R_ADDR, R_DATA}
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
- Sub-module axi_lite_arb_rr2 is the two-way round-robin grant plus last-grant pointer.
  - Inputs: req[1:0], advance. Outputs: grant_idx.
  - Instantiated once for write and once for read.

## Test plan
- Single write from s0 (awaddr 0x8000_1000, wdata 0xDEADBEEF, w one cycle before aw):
  - Master sees one aw and one w. bresp OKAY returns only to s0.
  - With remap: m_axi_awaddr=0x0000_1000. Without remap: 0x8000_1000.
- s0 and s1 assert arvalid in the same cycle, repeated 4 times:
  - Grants alternate s0,s1,s0,s1.
  - rdata 0x11111111 and 0x22222222 route to the correct requester; the other's rvalid stays 0.
- Concurrent s0 write and s1 read, slave responses with random 0–5 cycle stalls:
  - Both complete; no cross-routing; no channel valid drops before ready.
- m_axi_bresp=SLVERR:
  - s1 receives bresp 2'b10. The next s0 write is granted within 1 cycle of the b handshake.
- areset asserted while in W_RESP:
  - Next cycle all outputs are 0 and both FSMs are IDLE.
  - After release, a tie between s0 and s1 grants s0.

Source files
------------

// File: rtl/axi_lite_arb_pkg.sv
// axi_lite_arb_pkg: FSM state types and AXI response codes shared by the 2:1 AXI4-Lite arbiter
package axi_lite_arb_pkg;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_arb_rr2.sv
// axi_lite_arb_rr2: two-way round-robin grant with a last-grant pointer (resets to 1 so side 0 wins the first tie)
module axi_lite_arb_rr2
    import axi_lite_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_idx
);

    logic last;

    // A lone requester wins; on a tie the side not granted last wins
    always_comb grant_idx = &req ? ~last : req[1];

    // Record the winner whenever the owner commits a grant
    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (advance)
            last <= grant_idx;
    end

endmodule

// File: rtl/axi_lite_arb_2to1.sv
// axi_lite_arb_2to1: two AXI4-Lite requesters sharing one master port; independent round-robin
// read and write paths, one outstanding transaction each. Define AXI_ARB_ADDR_REMAP_EN to clear
// the address MSB on the master side.
module axi_lite_arb_2to1
    import axi_lite_arb_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic [2:0]                    s0_axi_awprot,
    input  logic                          s0_axi_awvalid,
    output logic                          s0_axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                          s0_axi_wvalid,
    output logic                          s0_axi_wready,
    output logic [1:0]                    s0_axi_bresp,
    output logic                          s0_axi_bvalid,
    input  logic                          s0_axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic [2:0]                    s0_axi_arprot,
    input  logic                          s0_axi_arvalid,
    output logic                          s0_axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]                    s0_axi_rresp,
    output logic                          s0_axi_rvalid,
    input  logic                          s0_axi_rready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic [2:0]                    s1_axi_awprot,
    input  logic                          s1_axi_awvalid,
    output logic                          s1_axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                          s1_axi_wvalid,
    output logic                          s1_axi_wready,
    output logic [1:0]                    s1_axi_bresp,
    output logic                          s1_axi_bvalid,
    input  logic                          s1_axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic [2:0]                    s1_axi_arprot,
    input  logic                          s1_axi_arvalid,
    output logic                          s1_axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]                    s1_axi_rresp,
    output logic                          s1_axi_rvalid,
    input  logic                          s1_axi_rready,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int AW = C_AXI_ADDR_WIDTH;

`ifdef AXI_ARB_ADDR_REMAP_EN
    localparam logic [AW-1:0] ADDR_MASK = {1'b0, {(AW-1){1'b1}}};
`else
    localparam logic [AW-1:0] ADDR_MASK = '1;
`endif

    wr_state_t  ws;
    rd_state_t  rs;
    logic       wg, rg, wi, ri, aw_done, w_done;
    logic [1:0] wreq, rreq;
    logic       wa, wb, ra, rd, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign wreq  = {s1_axi_awvalid, s0_axi_awvalid};
    assign rreq  = {s1_axi_arvalid, s0_axi_arvalid};
    assign wa    = ws == W_ADDR;
    assign wb    = ws == W_RESP;
    assign ra    = rs == R_ADDR;
    assign rd    = rs == R_DATA;
    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bvalid & m_axi_bready;
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rvalid & m_axi_rready;

    // The pointer is only consulted in IDLE, so advancing it at grant time is
    // indistinguishable from advancing it at completion (reset clears both)
    axi_lite_arb_rr2 u_wr_rr (
        .clk       (aclk),
        .rst       (areset),
        .req       (wreq),
        .advance   ((ws == W_IDLE) & |wreq),
        .grant_idx (wi)
    );

    axi_lite_arb_rr2 u_rd_rr (
        .clk       (aclk),
        .rst       (areset),
        .req       (rreq),
        .advance   ((rs == R_IDLE) & |rreq),
        .grant_idx (ri)
    );

    // Master side: granted requester's channels, zero outside the owning state
    assign m_axi_awvalid = wa & ~aw_done & (wg ? s1_axi_awvalid : s0_axi_awvalid);
    assign m_axi_awaddr  = wa ? (wg ? s1_axi_awaddr : s0_axi_awaddr) & ADDR_MASK : '0;
    assign m_axi_awprot  = wa ? (wg ? s1_axi_awprot : s0_axi_awprot) : '0;
    assign m_axi_wvalid  = wa & ~w_done & (wg ? s1_axi_wvalid : s0_axi_wvalid);
    assign m_axi_wdata   = wa ? (wg ? s1_axi_wdata : s0_axi_wdata) : '0;
    assign m_axi_wstrb   = wa ? (wg ? s1_axi_wstrb : s0_axi_wstrb) : '0;
    assign m_axi_bready  = wb & (wg ? s1_axi_bready : s0_axi_bready);
    assign m_axi_arvalid = ra & (rg ? s1_axi_arvalid : s0_axi_arvalid);
    assign m_axi_araddr  = ra ? (rg ? s1_axi_araddr : s0_axi_araddr) & ADDR_MASK : '0;
    assign m_axi_arprot  = ra ? (rg ? s1_axi_arprot : s0_axi_arprot) : '0;
    assign m_axi_rready  = rd & (rg ? s1_axi_rready : s0_axi_rready);

    // Requester side: only the granted requester sees readies and responses
    assign s0_axi_awready = wa & ~wg & ~aw_done & m_axi_awready;
    assign s1_axi_awready = wa &  wg & ~aw_done & m_axi_awready;
    assign s0_axi_wready  = wa & ~wg & ~w_done & m_axi_wready;
    assign s1_axi_wready  = wa &  wg & ~w_done & m_axi_wready;
    assign s0_axi_bvalid  = wb & ~wg & m_axi_bvalid;
    assign s1_axi_bvalid  = wb &  wg & m_axi_bvalid;
    assign s0_axi_bresp   = (wb & ~wg) ? m_axi_bresp : '0;
    assign s1_axi_bresp   = (wb &  wg) ? m_axi_bresp : '0;
    assign s0_axi_arready = ra & ~rg & m_axi_arready;
    assign s1_axi_arready = ra &  rg & m_axi_arready;
    assign s0_axi_rvalid  = rd & ~rg & m_axi_rvalid;
    assign s1_axi_rvalid  = rd &  rg & m_axi_rvalid;
    assign s0_axi_rdata   = (rd & ~rg) ? m_axi_rdata : '0;
    assign s1_axi_rdata   = (rd &  rg) ? m_axi_rdata : '0;
    assign s0_axi_rresp   = (rd & ~rg) ? m_axi_rresp : '0;
    assign s1_axi_rresp   = (rd &  rg) ? m_axi_rresp : '0;

    // Write path: grant, collect aw and w in either order, then wait for b
    always_ff @(posedge aclk) begin
        if (areset) begin
            ws      <= W_IDLE;
            wg      <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (ws)
                W_IDLE: if (|wreq) begin
                    ws      <= W_ADDR;
                    wg      <= wi;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                W_ADDR: begin
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                    if ((aw_done | aw_hs) & (w_done | w_hs))
                        ws <= W_RESP;
                end
                W_RESP: if (b_hs) ws <= W_IDLE;
                default: ws <= W_IDLE;
            endcase
        end
    end

    // Read path: grant, address handshake, then wait for r
    always_ff @(posedge aclk) begin
        if (areset) begin
            rs <= R_IDLE;
            rg <= 1'b0;
        end else begin
            case (rs)
                R_IDLE: if (|rreq) begin
                    rs <= R_ADDR;
                    rg <= ri;
                end
                R_ADDR: if (ar_hs) rs <= R_DATA;
                R_DATA: if (r_hs) rs <= R_IDLE;
                default: rs <= R_IDLE;
            endcase
        end
    end

endmodule
